simd_issue_packer: RTL and testbench

- Upstream feeder for simd_array.
- Accepts a vector command (opcode, element count) plus a scalar stream of operand pairs (a, b) over a valid/ready handshake.
- Packs elements into WIDTH-lane operand vectors, issues each chunk to the array with a one-cycle run pulse, and waits for the array's valid before packing the next chunk.
- Zero-pads the final partial chunk and signals command completion.

---
 rtl/simd_issue_packer.sv | 191 +++++++++++++++++++
 tb/tb_simd_issue_packer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_issue_packer.sv
// Packs a scalar (a, b) operand stream into WIDTH-lane vectors and issues them to simd_array.
// Optional macro SIMD_PACK_ERR_EN adds o_err and rejects op==3 / len==0 commands.
module simd_issue_packer #(
   parameter int unsigned UNIT_SIZE = 32,
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned LEN_W     = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_cmd_valid,
   output logic                       o_cmd_ready,
   input  logic [1:0]                 i_cmd_op,
   input  logic [LEN_W-1:0]           i_cmd_len,
   input  logic                       i_elem_valid,
   output logic                       o_elem_ready,
   input  logic [UNIT_SIZE-1:0]       i_elem_a,
   input  logic [UNIT_SIZE-1:0]       i_elem_b,
   output logic                       o_run,
   output logic [1:0]                 o_op,
   output logic [WIDTH*UNIT_SIZE-1:0] o_a,
   output logic [WIDTH*UNIT_SIZE-1:0] o_b,
   input  logic                       i_arr_valid,
   output logic                       o_chunk_last,
   output logic                       o_busy,
`ifdef SIMD_PACK_ERR_EN
   output logic                       o_err,
`endif
   output logic                       o_done
);

   localparam int unsigned VEC_W = WIDTH * UNIT_SIZE;
   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   logic [1:0]       state_q,     state_d;
   logic [1:0]       op_q,        op_d;
   logic [VEC_W-1:0] a_q,         a_d;
   logic [VEC_W-1:0] b_q,         b_d;
   logic [LEN_W-1:0] rem_q,       rem_d;
   logic [IDX_W-1:0] idx_q,       idx_d;
   logic             run_q,       run_d;
   logic             last_q,      last_d;
   logic             done_q,      done_d;
   logic             cmd_rdy_q,   cmd_rdy_d;
   logic             elem_rdy_q,  elem_rdy_d;
   logic             busy_q,      busy_d;
`ifdef SIMD_PACK_ERR_EN
   logic             err_q,       err_d;
`endif

   logic cmd_hs;
   logic elem_hs;

   assign cmd_hs  = i_cmd_valid  & cmd_rdy_q;
   assign elem_hs = i_elem_valid & elem_rdy_q;

   // Next-state and next-output logic; handshake flags are decoded one cycle ahead.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
`ifdef SIMD_PACK_ERR_EN
      err_d   = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (cmd_hs) begin
               op_d  = i_cmd_op;
               rem_d = i_cmd_len;
               a_d   = '0;
               b_d   = '0;
               idx_d = '0;
`ifdef SIMD_PACK_ERR_EN
               if ((i_cmd_op == 2'd3) || (i_cmd_len == '0)) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  state_d = S_FILL;
               end
`else
               if (i_cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_FILL;
               end
`endif
            end
         end

         S_FILL: begin
            if (elem_hs) begin
               a_d[idx_q*UNIT_SIZE +: UNIT_SIZE] = i_elem_a;
               b_d[idx_q*UNIT_SIZE +: UNIT_SIZE] = i_elem_b;
               idx_d = idx_q + IDX_W'(1);
               rem_d = rem_q - LEN_W'(1);
               if ((idx_q == IDX_W'(WIDTH - 1)) || (rem_q == LEN_W'(1))) begin
                  state_d = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (i_arr_valid) begin
               if (rem_q == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  a_d     = '0;
                  b_d     = '0;
                  idx_d   = '0;
                  state_d = S_FILL;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      run_d      = (state_d == S_ISSUE);
      last_d     = (state_d == S_ISSUE) && (rem_d == '0);
      cmd_rdy_d  = (state_d == S_IDLE);
      elem_rdy_d = (state_d == S_FILL);
      busy_d     = (state_d != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rem_q      <= '0;
         idx_q      <= '0;
         run_q      <= 1'b0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
         cmd_rdy_q  <= 1'b1;
         elem_rdy_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef SIMD_PACK_ERR_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rem_q      <= rem_d;
         idx_q      <= idx_d;
         run_q      <= run_d;
         last_q     <= last_d;
         done_q     <= done_d;
         cmd_rdy_q  <= cmd_rdy_d;
         elem_rdy_q <= elem_rdy_d;
         busy_q     <= busy_d;
`ifdef SIMD_PACK_ERR_EN
         err_q      <= err_d;
`endif
      end
   end

   assign o_cmd_ready  = cmd_rdy_q;
   assign o_elem_ready = elem_rdy_q;
   assign o_run        = run_q;
   assign o_op         = op_q;
   assign o_a          = a_q;
   assign o_b          = b_q;
   assign o_chunk_last = last_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
`ifdef SIMD_PACK_ERR_EN
   assign o_err        = err_q;
`endif

endmodule

// File: tb/tb_simd_issue_packer.sv
// Directed, table-driven bench for simd_issue_packer (WIDTH=5, UNIT_SIZE=32, LEN_W=16).
module tb_simd_issue_packer;

   logic         i_clk;
   logic         i_rstn;
   logic         i_cmd_valid;
   logic         o_cmd_ready;
   logic [1:0]   i_cmd_op;
   logic [15:0]  i_cmd_len;
   logic         i_elem_valid;
   logic         o_elem_ready;
   logic [31:0]  i_elem_a;
   logic [31:0]  i_elem_b;
   logic         o_run;
   logic [1:0]   o_op;
   logic [159:0] o_a;
   logic [159:0] o_b;
   logic         i_arr_valid;
   logic         o_chunk_last;
   logic         o_busy;
   logic         o_done;
`ifdef SIMD_PACK_ERR_EN
   logic         o_err;
`endif

   int total;
   int bad;

   simd_issue_packer #(.UNIT_SIZE(32), .WIDTH(5), .LEN_W(16)) dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_cmd_valid  (i_cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_op     (i_cmd_op),
      .i_cmd_len    (i_cmd_len),
      .i_elem_valid (i_elem_valid),
      .o_elem_ready (o_elem_ready),
      .i_elem_a     (i_elem_a),
      .i_elem_b     (i_elem_b),
      .o_run        (o_run),
      .o_op         (o_op),
      .o_a          (o_a),
      .o_b          (o_b),
      .i_arr_valid  (i_arr_valid),
      .o_chunk_last (o_chunk_last),
      .o_busy       (o_busy),
`ifdef SIMD_PACK_ERR_EN
      .o_err        (o_err),
`endif
      .o_done       (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      string              name;
      logic [1:0]         op;
      int                 len;
      logic [9:0][31:0]   a;
      logic [9:0][31:0]   b;
      int                 nchunks;
      int                 nacc;
      bit                 err;
      logic [1:0][159:0]  xa;
      logic [1:0][159:0]  xb;
   } vec_t;

   vec_t tv[7];
   vec_t rst_vec;

   function automatic logic [159:0] l5(input int x[5]);
      logic [159:0] r;
      for (int i = 0; i < 5; i++) r[i*32 +: 32] = x[i];
      return r;
   endfunction

   function automatic vec_t mk(input string nm, input logic [1:0] op, input int len,
                               input int a[10], input int b[10], input int nch,
                               input int xa0[5], input int xb0[5], input int xa1[5], input int xb1[5]);
      vec_t v;
      v.name = nm;
      v.op = op;
      v.len = len;
      for (int i = 0; i < 10; i++) begin
         v.a[i] = a[i];
         v.b[i] = b[i];
      end
      v.nchunks = nch;
      v.nacc = len;
      v.err = 1'b0;
      v.xa[0] = l5(xa0);
      v.xb[0] = l5(xb0);
      v.xa[1] = l5(xa1);
      v.xb[1] = l5(xb1);
`ifdef SIMD_PACK_ERR_EN
      if ((op == 2'd3) || (len == 0)) begin
         v.nchunks = 0;
         v.nacc = 0;
         v.err = 1'b1;
      end
`endif
      return v;
   endfunction

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Drives one command and its elements, checking every issued chunk and the done pulse.
   task automatic do_cmd(input vec_t v, input bit gap, input int dly, input bit spur);
      int ei = 0;
      int chunk = 0;
      int cnt = 0;
      bit pend = 0;
      bit lastv = 0;
      bit done_seen = 0;
      bit tog = 0;
      bit exp_done;
      chk({v.name, ":cmd_ready"}, 160'(o_cmd_ready), 160'(1));
      i_cmd_valid = 1'b1;
      i_cmd_op = v.op;
      i_cmd_len = 16'(v.len);
      @(posedge i_clk); #1;
      i_cmd_valid = 1'b0;
      for (int it = 0; it < 400 && !done_seen; it++) begin
         exp_done = ((v.nchunks == 0) && (it == 0)) || lastv;
         lastv = 1'b0;
         i_arr_valid = 1'b0;
         chk({v.name, ":done"}, 160'(o_done), 160'(exp_done));
         if (o_done || exp_done) begin
            done_seen = 1'b1;
            i_elem_valid = 1'b0;
            chk({v.name, ":accepted"}, 160'(ei), 160'(v.nacc));
            chk({v.name, ":chunks"}, 160'(chunk), 160'(v.nchunks));
`ifdef SIMD_PACK_ERR_EN
            chk({v.name, ":err"}, 160'(o_err), 160'(v.err));
`endif
         end else begin
            chk({v.name, ":busy"}, 160'({o_busy, o_cmd_ready}), 160'(2'b10));
            if (o_run) begin
               if (chunk >= v.nchunks) begin
                  chk({v.name, ":extra_run"}, 160'(chunk), 160'(v.nchunks - 1));
               end else begin
                  chk({v.name, ":run_a"}, o_a, v.xa[chunk]);
                  chk({v.name, ":run_b"}, o_b, v.xb[chunk]);
                  chk({v.name, ":run_op"}, 160'(o_op), 160'(v.op));
                  chk({v.name, ":run_last"}, 160'(o_chunk_last), 160'(chunk == v.nchunks - 1));
               end
               chk({v.name, ":run_elem_ready"}, 160'(o_elem_ready), 160'(0));
               chunk++;
               pend = 1'b1;
               cnt = dly;
               i_arr_valid = spur;
            end else if (pend) begin
               chk({v.name, ":wait_a"}, o_a, v.xa[chunk-1]);
               chk({v.name, ":wait_elem_ready"}, 160'(o_elem_ready), 160'(0));
               if (cnt == 0) begin
                  i_arr_valid = 1'b1;
                  pend = 1'b0;
                  lastv = (chunk == v.nchunks);
               end else begin
                  cnt--;
               end
            end
            tog = ~tog;
            i_elem_valid = (ei < v.len) && (!gap || tog);
            i_elem_a = (ei < 10) ? v.a[ei] : 32'h0;
            i_elem_b = (ei < 10) ? v.b[ei] : 32'h0;
            if (i_elem_valid && o_elem_ready) ei++;
         end
         if (!done_seen) begin
            @(posedge i_clk); #1;
         end
      end
      if (!done_seen) begin
         total++;
         bad++;
         $display("FAIL %s:timeout got no done want done", v.name);
      end
      i_elem_valid = 1'b0;
      i_arr_valid = 1'b0;
      @(posedge i_clk); #1;
      chk({v.name, ":done_pulse"}, 160'(o_done), 160'(0));
      chk({v.name, ":idle"}, 160'({o_busy, o_cmd_ready, o_elem_ready, o_run}), 160'(4'b0100));
`ifdef SIMD_PACK_ERR_EN
      chk({v.name, ":err_pulse"}, 160'(o_err), 160'(0));
`endif
   endtask

   initial begin
      int z5[5];
      int z10[10];
      z5 = '{0, 0, 0, 0, 0};
      z10 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      total = 0;
      bad = 0;
      i_rstn = 1'b0;
      i_cmd_valid = 1'b0;
      i_cmd_op = 2'd0;
      i_cmd_len = 16'd0;
      i_elem_valid = 1'b0;
      i_elem_a = 32'd0;
      i_elem_b = 32'd0;
      i_arr_valid = 1'b0;

      tv[0] = mk("add5", 2'd0, 5, '{0,1,2,3,4,0,0,0,0,0}, '{0,1,2,3,4,0,0,0,0,0}, 1,
                 '{0,1,2,3,4}, '{0,1,2,3,4}, z5, z5);
      tv[1] = mk("sub7", 2'd1, 7, '{6,7,8,9,10,11,12,0,0,0}, '{0,1,2,3,4,5,6,0,0,0}, 2,
                 '{6,7,8,9,10}, '{0,1,2,3,4}, '{11,12,0,0,0}, '{5,6,0,0,0});
      tv[2] = mk("mac10", 2'd2, 10, '{4,6,8,10,12,2,4,6,8,91}, '{2,3,4,5,14,3,4,5,6,-1}, 2,
                 '{4,6,8,10,12}, '{2,3,4,5,14}, '{2,4,6,8,91}, '{3,4,5,6,-1});
      tv[3] = mk("len0", 2'd0, 0, z10, z10, 0, z5, z5, z5, z5);
      tv[4] = mk("op3", 2'd3, 4, '{100,200,300,400,0,0,0,0,0,0}, '{1,2,3,4,0,0,0,0,0,0}, 1,
                 '{100,200,300,400,0}, '{1,2,3,4,0}, z5, z5);
      tv[5] = mk("add1", 2'd0, 1, '{7,0,0,0,0,0,0,0,0,0}, '{9,0,0,0,0,0,0,0,0,0}, 1,
                 '{7,0,0,0,0}, '{9,0,0,0,0}, z5, z5);
      tv[6] = mk("sub6", 2'd1, 6, '{1,2,3,4,5,6,0,0,0,0}, '{10,11,12,13,14,15,0,0,0,0}, 2,
                 '{1,2,3,4,5}, '{10,11,12,13,14}, '{6,0,0,0,0}, '{15,0,0,0,0});
      rst_vec = mk("after_rst", 2'd1, 2, '{21,22,0,0,0,0,0,0,0,0}, '{31,32,0,0,0,0,0,0,0,0}, 1,
                   '{21,22,0,0,0}, '{31,32,0,0,0}, z5, z5);

      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_outputs", 160'({o_cmd_ready, o_elem_ready, o_run, o_busy, o_done, o_chunk_last, o_op}),
          160'(8'b1000_0000));
      chk("reset_a", o_a, 160'(0));
      @(negedge i_clk);
      i_rstn = 1'b1;
      @(posedge i_clk); #1;

      for (int k = 0; k < 7; k++) begin
         do_cmd(tv[k], 1'b0, 0, 1'b0);
      end

      // Sparse elements, slow array and a stray valid during the issue cycle.
      do_cmd(tv[2], 1'b1, 10, 1'b1);
      do_cmd(tv[1], 1'b1, 3, 1'b1);

      // Reset after three elements of a five-element command.
      i_cmd_valid = 1'b1;
      i_cmd_op = 2'd2;
      i_cmd_len = 16'd5;
      @(posedge i_clk); #1;
      i_cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_elem_valid = 1'b1;
         i_elem_a = 32'(50 + k);
         i_elem_b = 32'(60 + k);
         @(posedge i_clk); #1;
      end
      i_elem_valid = 1'b0;
      chk("pre_rst_a", o_a, l5('{50, 51, 52, 0, 0}));
      i_rstn = 1'b0;
      #1;
      chk("mid_rst_outputs", 160'({o_cmd_ready, o_elem_ready, o_run, o_busy, o_done, o_chunk_last, o_op}),
          160'(8'b1000_0000));
      chk("mid_rst_a", o_a, 160'(0));
      chk("mid_rst_b", o_b, 160'(0));
      @(negedge i_clk);
      i_rstn = 1'b1;
      @(posedge i_clk); #1;
      do_cmd(rst_vec, 1'b0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
